// File: rtl/lwc_do_unshare.sv
`default_nettype none
// ============================================================================
// Module   : lwc_do_unshare
// Purpose  : Receives Boolean-shared output words from the masked core,
//            recombines the shares by XOR and buffers the unshared words in a
//            small FIFO for an unprotected consumer.  Counts the words of each
//            message and reports the count when the last word leaves.
// Revision : 1.0 - initial release
// ============================================================================
module lwc_do_unshare #(
  parameter int W          = 32,
  parameter int PDI_SHARES = 4,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PDI_SHARES*W-1:0] do_data,
  input  logic                    do_valid,
  input  logic                    do_last,
  output logic                    do_ready,
  output logic [W-1:0]            out_data,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [15:0]             msg_words,
  output logic                    msg_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_data [DEPTH];
  logic          mem_last [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   word_cnt;
  logic [15:0]   word_cnt_inc;
  logic [W-1:0]  unshared;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Recombine the shares; only the XOR result ever reaches a register.
  always_comb begin
    unshared = '0;
    for (int i = 0; i < PDI_SHARES; i++) begin
      unshared = unshared ^ do_data[i*W +: W];
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Ready depends only on occupancy (no bypass when full); held low while
  // the reset input is asserted so nothing is accepted during reset.
  assign do_ready  = rst & ~full;
  assign out_valid = ~empty;
  assign push      = do_valid & do_ready;
  assign pop       = out_valid & out_ready;

  // Head of the FIFO; forced to zero when empty so stale entries never show.
  assign out_data = empty ? '0 : mem_data[rd_ptr];
  assign out_last = empty ? 1'b0 : mem_last[rd_ptr];

  // Storage array: written at the accept edge, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= unshared;
      mem_last[wr_ptr] <= do_last;
    end
  end

  // Pointers and occupancy; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign word_cnt_inc = (word_cnt == 16'hFFFF) ? 16'hFFFF : word_cnt + 16'd1;

  // Per-message word counter with completion report on the last pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt  <= '0;
      msg_words <= '0;
      msg_done  <= 1'b0;
    end else begin
      msg_done <= 1'b0;
      if (pop) begin
        if (out_last) begin
          msg_words <= word_cnt_inc;
          msg_done  <= 1'b1;
          word_cnt  <= '0;
        end else begin
          word_cnt <= word_cnt_inc;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lwc_do_unshare.sv
`default_nettype none
// ============================================================================
// Module   : tb_lwc_do_unshare
// Purpose  : Self-checking bench for lwc_do_unshare: table of single-word
//            vectors plus directed backpressure, full, streaming and reset
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lwc_do_unshare;

  localparam int W  = 32;
  localparam int NS = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NS*W-1:0] do_data;
  logic           do_valid;
  logic           do_last;
  logic           do_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_last;
  logic           out_ready;
  logic [15:0]    msg_words;
  logic           msg_done;

  int total = 0;
  int bad   = 0;
  int done_words[$];

  lwc_do_unshare #(.W(W), .PDI_SHARES(NS), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .do_data(do_data), .do_valid(do_valid), .do_last(do_last), .do_ready(do_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .msg_words(msg_words), .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0][W-1:0] sh;
    logic                 last;
    logic [W-1:0]         word;
    logic [15:0]          words;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [W-1:0] w, input logic l);
    do_data  = {{(NS-1)*W{1'b0}}, w};
    do_last  = l;
    do_valid = 1'b1;
  endtask

  // Stream n words back to back; bit j of lmask marks word j as last.
  task automatic stream(input int n, input logic [31:0] lmask);
    logic [W-1:0]         exp[32];
    logic [NS-1:0][W-1:0] sh;
    done_words.delete();
    out_ready = 1'b1;
    for (int c = 0; c <= n; c++) begin
      if (c < n) begin
        for (int s = 0; s < NS; s++) sh[s] = $urandom;
        exp[c]   = sh[0] ^ sh[1] ^ sh[2] ^ sh[3];
        do_data  = sh;
        do_last  = lmask[c];
        do_valid = 1'b1;
        chk("stream_ready", 64'(do_ready), 64'd1);
      end else begin
        do_valid = 1'b0;
      end
      if (c >= 1) begin
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_data", 64'(out_data), 64'(exp[c-1]));
      end
      step();
      if (msg_done) done_words.push_back(int'(msg_words));
    end
    do_valid = 1'b0;
  endtask

  initial begin
    vt[0] = '{sh: {32'h88888888, 32'h44444444, 32'h22222222, 32'h11111111}, last: 1'b1, word: 32'hFFFFFFFF, words: 16'd1};
    vt[1] = '{sh: {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000}, last: 1'b0, word: 32'h00000000, words: 16'd0};
    vt[2] = '{sh: {32'h0000FFFF, 32'h00000000, 32'h5A5A5A5A, 32'hA5A5A5A5}, last: 1'b0, word: 32'hFFFF0000, words: 16'd0};
    vt[3] = '{sh: {32'h00000000, 32'hDEADBEEF, 32'h12345678, 32'h12345678}, last: 1'b1, word: 32'hDEADBEEF, words: 16'd3};
    vt[4] = '{sh: {32'h01010101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, last: 1'b1, word: 32'hFEFEFEFE, words: 16'd1};

    rst = 1'b0; do_data = '0; do_valid = 1'b0; do_last = 1'b0; out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_do_ready", 64'(do_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_msg_words", 64'(msg_words), 64'd0);
    chk("rst_msg_done", 64'(msg_done), 64'd0);
    #10 rst = 1'b1;
    #1;
    chk("rel_do_ready", 64'(do_ready), 64'd1);
    step();

    // Table of single-word transfers with an always-ready consumer
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_data = vt[i].sh; do_last = vt[i].last; do_valid = 1'b1;
      chk("vec_do_ready", 64'(do_ready), 64'd1);
      step();
      do_valid = 1'b0;
      chk("vec_out_valid", 64'(out_valid), 64'd1);
      chk("vec_out_data", 64'(out_data), 64'(vt[i].word));
      chk("vec_out_last", 64'(out_last), 64'(vt[i].last));
      step();
      chk("vec_msg_done", 64'(msg_done), 64'(vt[i].last));
      if (vt[i].last) chk("vec_msg_words", 64'(msg_words), 64'(vt[i].words));
      chk("vec_empty", 64'(out_valid), 64'd0);
    end
    step();
    chk("vec_done_clear", 64'(msg_done), 64'd0);

    // Backpressure: 5 offered, 4 accepted
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(32'h100 + 32'(i), i == 3);
      chk("bp_do_ready", 64'(do_ready), (i < 4) ? 64'd1 : 64'd0);
      step();
    end
    do_valid = 1'b0;
    chk("bp_head", 64'(out_data), 64'h100);
    chk("bp_head_stable", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp_ready_back", 64'(do_ready), 64'd1);
    for (int i = 1; i < 4; i++) begin
      chk("bp_order", 64'(out_data), 64'h100 + 64'(i));
      step();
    end
    chk("bp_drained", 64'(out_valid), 64'd0);
    chk("bp_msg_done", 64'(msg_done), 64'd1);
    chk("bp_msg_words", 64'(msg_words), 64'd4);

    // Full FIFO with a simultaneous pop: no accept on that edge
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(32'h200 + 32'(i), 1'b0);
      step();
    end
    put(32'h204, 1'b1);
    out_ready = 1'b1;
    chk("full_no_ready", 64'(do_ready), 64'd0);
    step();
    chk("full_pop_ready", 64'(do_ready), 64'd1);
    chk("full_pop_head", 64'(out_data), 64'h201);
    step();
    do_valid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      chk("full_order", 64'(out_data), 64'h200 + 64'(i));
      chk("full_last", 64'(out_last), (i == 4) ? 64'd1 : 64'd0);
      step();
    end
    chk("full_msg_done", 64'(msg_done), 64'd1);
    chk("full_msg_words", 64'(msg_words), 64'd5);

    // Streaming 16-word message at one word per cycle
    stream(16, 32'h0000_8000);
    chk("stream16_pulses", 64'(done_words.size()), 64'd1);
    if (done_words.size() > 0) chk("stream16_words", 64'(done_words[0]), 64'd16);

    // Back-to-back messages of 3 then 2 words
    stream(5, 32'h0000_0014);
    chk("b2b_pulses", 64'(done_words.size()), 64'd2);
    if (done_words.size() > 1) begin
      chk("b2b_words0", 64'(done_words[0]), 64'd3);
      chk("b2b_words1", 64'(done_words[1]), 64'd2);
    end

    // Asynchronous reset with two words buffered mid-message
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      put(32'h300 + 32'(i), 1'b0);
      step();
    end
    do_valid = 1'b0;
    chk("mid_buffered", 64'(out_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_do_ready", 64'(do_ready), 64'd0);
    chk("mid_msg_words", 64'(msg_words), 64'd0);
    #3 rst = 1'b1;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("post_empty", 64'(out_valid), 64'd0);
      chk("post_no_done", 64'(msg_done), 64'd0);
      step();
    end
    chk("post_words", 64'(msg_words), 64'd0);
    put(32'hCAFE0001, 1'b1);
    step();
    do_valid = 1'b0;
    chk("post_data", 64'(out_data), 64'hCAFE0001);
    step();
    chk("post_msg_done", 64'(msg_done), 64'd1);
    chk("post_msg_words", 64'(msg_words), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lwc_do_unshare.md
Name: lwc_do_unshare

Overview:
- Receiver at the far end of the masked core's output (do) interface: accepts PDI_SHARES-way Boolean-shared output words under valid/ready, recombines them by XOR, and buffers them in a small FIFO.
- Presents unshared words with a last flag to the host-side consumer.
- Reports the word count of each completed message.
- Used in the test harness and in any system wrapper that hands the core's result to an unprotected domain.

Parameters:
- W, 32, width of one share / one output word
- PDI_SHARES, 4, number of Boolean shares on do_data (third-order core)
- DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous active-low reset
- do_data  input  PDI_SHARES*W  shared word; share i at bits [i*W +: W]
- do_valid  input  1  do_data/do_last valid
- do_last  input  1  word is last of message
- do_ready  output  1  block accepts the do word this cycle
- out_data  output  W  unshared word (FIFO head)
- out_valid  output  1  out_data valid
- out_last  output  1  head word is last of message
- out_ready  input  1  consumer accepts head word
- msg_words  output  16  word count of the most recently completed message
- msg_done  output  1  one-cycle pulse when a last word leaves on out

Behaviour:
- Reset (rst=0, async): FIFO empty, pointers 0, word counter 0, out_valid=0, out_data=0, out_last=0, msg_words=0, msg_done=0, do_ready=0 while rst asserted. After release, do_ready=1 from the first cycle.
- Recombination: word = XOR over i of do_data[i*W +: W], computed only on the write path. The {word, do_last} pair is written to FIFO at the accept edge. Individual shares are not stored.
- Input handshake: accept when do_valid & do_ready. do_ready = !full, registered-free but depending only on occupancy. No full-bypass: when full, do_ready=0 even if a pop occurs in the same cycle.
- Output handshake: pop when out_valid & out_ready. out_valid = !empty. out_data/out_last show the FIFO head and are stable while out_valid & !out_ready.
- Latency: word accepted at edge n is visible on out at edge n+1 (FIFO empty case); no fall-through in the same cycle.
- Simultaneous push and pop when neither full nor empty: both occur, occupancy unchanged. Push and pop when empty: push only (pop impossible).
- Occupancy: count register 0..DEPTH; pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Word counter: increments by 1 on each output handshake, saturating at 16'hFFFF.
  - On an output handshake with out_last=1: msg_words <= counter+1 (saturated), msg_done=1 for exactly that following cycle, counter <= 0.
  - msg_words holds until the next completed message.
- Back-to-back messages: a last word followed immediately by the next message's first word needs no bubble; counter restarts cleanly.
- do_valid may drop without completing a message; state is retained indefinitely.
- Reset mid-message: all buffered data is discarded and the counter is cleared. No msg_done is generated.

Test Plan:
- Reset then single word: shares {32'h11111111, 32'h22222222, 32'h44444444, 32'h88888888} with do_last=1 and out_ready=1 → out_data=32'hFFFFFFFF one cycle after accept, out_last=1, then msg_done pulse and msg_words=1.
- Backpressure: out_ready=0, push 5 words with DEPTH=4 → exactly 4 accepted, do_ready=0 after the 4th. Raise out_ready → words emerge in order, and do_ready returns 1 the cycle after the first pop.
- Full with simultaneous pop: FIFO full, out_ready=1 and do_valid=1 in the same cycle → no accept that cycle (do_ready=0), one pop; accept occurs next cycle.
- Streaming: 16-word message, shares random, do_valid=out_ready=1 continuously → 1 word/cycle throughput, every out_data equals the XOR of its shares, msg_words=16.
- Back-to-back messages of 3 then 2 words → two msg_done pulses with msg_words=3 then 2.
- Async reset asserted mid-message with 2 words buffered → out_valid=0 immediately; after release the FIFO is empty, msg_words=0, and no msg_done pulse.
